// File: rtl/button_event_decoder_pkg.sv
// Shared types for the push-button gesture path: decoder FSM states and the
// gesture event encoding consumed by the clock mode/set FSM.
package button_event_decoder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        HELD
    } state_t;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_SHORT,
        EV_DOUBLE,
        EV_LONG,
        EV_REPEAT
    } btn_event_t;

    // True when the tick counter has reached the last tick of a window of len ticks
    function automatic logic cnt_last(input logic [15:0] cnt, input int len);
        return (cnt == 16'(len - 1));
    endfunction

endpackage

// File: rtl/button_event_decoder_tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 and flags the wrap cycle as a tick.
// clr restarts the count so intervals can be measured from an arbitrary event.
module tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick_o
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] pre_q;

    assign tick_o = (pre_q == PW'(TICK_DIV - 1));

    // Prescaler count, restarting on wrap or on an external clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pre_q <= '0;
        else if (clr || tick_o)
            pre_q <= '0;
        else
            pre_q <= pre_q + PW'(1);
    end

endmodule

// File: rtl/button_event_decoder.sv
// Button gesture decoder: turns the debounced button level into one-cycle
// short / double / long / auto-repeat pulses for the mode FSM.
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int TICK_DIV = 100000,
    parameter int LONG_T   = 1000,
    parameter int DOUBLE_T = 300,
    parameter int REPEAT_T = 200,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_level,
    input  logic enable,
    output logic short_o,
    output logic double_o,
    output logic long_o,
    output logic repeat_o,
    output logic busy_o
);

    state_t           state_q, state_d;
    btn_event_t       ev_q, ev_d;
    logic             btn_prev_q;
    logic             busy_q;
    logic [CNT_W-1:0] tick_cnt_q;
    logic             tick;
    logic             clr;
    logic             press, rel;
    logic             long_hit, dbl_hit, rep_hit;

    assign press = btn_level & ~btn_prev_q;
    assign rel   = ~btn_level & btn_prev_q;

    assign long_hit = tick && (tick_cnt_q == CNT_W'(LONG_T - 1));
    assign dbl_hit  = tick && (tick_cnt_q == CNT_W'(DOUBLE_T - 1));
    assign rep_hit  = tick && (tick_cnt_q == CNT_W'(REPEAT_T - 1));

    // Timing restarts on every state change, on each repeat pulse, and while disabled
    assign clr = !enable || (state_d != state_q) || (ev_d == EV_REPEAT);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .tick_o (tick)
    );

    // Edge-detect history keeps tracking even while disabled, so a held button
    // across enable rising is not mistaken for a fresh press
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            btn_prev_q <= 1'b0;
        else
            btn_prev_q <= btn_level;
    end

    // Tick counter: counts ticks since the last restart, saturating at all-ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tick_cnt_q <= '0;
        else if (clr)
            tick_cnt_q <= '0;
        else if (tick && (tick_cnt_q != '1))
            tick_cnt_q <= tick_cnt_q + CNT_W'(1);
    end

    // State, event and busy registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ev_q    <= EV_NONE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ev_q    <= ev_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    // Next-state logic; a release or second press wins over a same-cycle timeout
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (press) state_d = PRESS1;
                PRESS1:  if (rel) state_d = WAIT2;
                         else if (long_hit) state_d = HELD;
                WAIT2:   if (press) state_d = PRESS2;
                         else if (dbl_hit) state_d = IDLE;
                PRESS2:  if (rel) state_d = IDLE;
                HELD:    if (rel) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic: pick the gesture event to be registered this cycle
    always_comb begin
        ev_d = EV_NONE;
        if (enable) begin
            case (state_q)
                PRESS1:  if (!rel && long_hit) ev_d = EV_LONG;
                WAIT2:   if (!press && dbl_hit) ev_d = EV_SHORT;
                PRESS2:  if (rel) ev_d = EV_DOUBLE;
                HELD:    if (!rel && rep_hit) ev_d = EV_REPEAT;
                default: ev_d = EV_NONE;
            endcase
        end
    end

    assign short_o  = (ev_q == EV_SHORT);
    assign double_o = (ev_q == EV_DOUBLE);
    assign long_o   = (ev_q == EV_LONG);
    assign repeat_o = (ev_q == EV_REPEAT);
    assign busy_o   = busy_q;

endmodule
